ping_pong_monitor: RTL and testbench

Receive-side checker for the parameterized ping-pong counter's output stream. It samples the counter value and bound settings, then:
- recovers the count direction;
- classifies every turnaround as a bound bounce or a mid-range flip;
- counts both kinds of turnaround;
- flags any sample sequence a legal counter cannot produce.

It sits downstream of the counter (or on a link carrying its value) as a self-check and statistics block.

---
 rtl/ping_pong_monitor.sv | 114 +++++++++++
 tb/tb_ping_pong_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ping_pong_monitor.sv
// Receive-side checker for a ping-pong counter stream: recovers direction,
// classifies and counts turnarounds, and flags sample sequences a legal counter cannot produce.
module ping_pong_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       sample,
    input  logic [3:0]       max,
    input  logic [3:0]       min,
    input  logic             clr,
    output logic             dir,
    output logic             dir_valid,
    output logic [CNT_W-1:0] bounce_cnt,
    output logic [CNT_W-1:0] flip_cnt,
    output logic             step_err,
    output logic             err_sticky
);

    typedef enum logic [1:0] {EMPTY, FIRST, TRACK} state_t;

    state_t             state, state_nxt;
    logic [3:0]         prev, prev_nxt;
    logic               dir_nxt, dir_valid_nxt;
    logic [CNT_W-1:0]   bounce_nxt, flip_nxt;
    logic               step_err_nxt, err_sticky_nxt;

    logic               range_ok, in_range, legal;
    logic               step_up, step_dn, step_zero;
    logic signed [4:0]  step;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Step is taken in 5-bit signed arithmetic so 15->0 reads as -15, never as a wrap to +1.
    assign step      = $signed({1'b0, sample}) - $signed({1'b0, prev});
    assign step_up   = (step == 5'sd1);
    assign step_dn   = (step == -5'sd1);
    assign step_zero = (step == 5'sd0);
    assign range_ok  = (max > min);
    assign in_range  = (sample >= min) && (sample <= max);

    always_comb begin
        state_nxt      = state;
        prev_nxt       = prev;
        dir_nxt        = dir;
        bounce_nxt     = bounce_cnt;
        flip_nxt       = flip_cnt;
        step_err_nxt   = 1'b0;
        err_sticky_nxt = err_sticky;
        legal          = 1'b0;

        if (in_valid) begin
            prev_nxt = sample;
            if (state == EMPTY) begin
                // With a collapsed range the first sample is taken as the reference unconditionally.
                if (!range_ok || in_range) state_nxt    = FIRST;
                else                       step_err_nxt = 1'b1;
            end else begin
                legal = range_ok ? (in_range && (step_up || step_dn || step_zero)) : step_zero;
                if (!legal) begin
                    step_err_nxt = 1'b1;
                    state_nxt    = in_range ? FIRST : EMPTY;
                end else if (state == FIRST) begin
                    if (step_up) begin
                        dir_nxt   = 1'b1;
                        state_nxt = TRACK;
                    end else if (step_dn) begin
                        dir_nxt   = 1'b0;
                        state_nxt = TRACK;
                    end
                end else if ((step_up && !dir) || (step_dn && dir)) begin
                    dir_nxt = !dir;
                    if ((dir && prev == max) || (!dir && prev == min)) bounce_nxt = sat_inc(bounce_cnt);
                    else                                               flip_nxt   = sat_inc(flip_cnt);
                end
            end
        end

        if (step_err_nxt) err_sticky_nxt = 1'b1;
        // Clear wins over any increment or sticky-set from the same sample.
        if (clr) begin
            bounce_nxt     = '0;
            flip_nxt       = '0;
            err_sticky_nxt = 1'b0;
        end
        dir_valid_nxt = (state_nxt == TRACK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            prev       <= 4'd0;
            dir        <= 1'b1;
            dir_valid  <= 1'b0;
            bounce_cnt <= '0;
            flip_cnt   <= '0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            dir        <= dir_nxt;
            dir_valid  <= dir_valid_nxt;
            bounce_cnt <= bounce_nxt;
            flip_cnt   <= flip_nxt;
            step_err   <= step_err_nxt;
            err_sticky <= err_sticky_nxt;
        end
    end

endmodule

// File: tb/tb_ping_pong_monitor.sv
// Bench for ping_pong_monitor: directed scenarios plus randomized counter-like traffic,
// all checked against a flag-based behavioural model of the stream rules.
module tb_ping_pong_monitor;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, clr;
    logic [3:0] sample, max, min;
    logic       dir, dir_valid, step_err, err_sticky;
    logic [7:0] bounce_cnt, flip_cnt;

    always #5 clk = ~clk;

    ping_pong_monitor #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sample(sample),
        .max(max), .min(min), .clr(clr), .dir(dir), .dir_valid(dir_valid),
        .bounce_cnt(bounce_cnt), .flip_cnt(flip_cnt), .step_err(step_err),
        .err_sticky(err_sticky)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: "have a reference sample" and "direction known" flags plus plain integer counts.
    bit m_has, m_known, m_dir, m_sticky, m_err;
    int m_prev, m_bounce, m_flip;
    localparam int SAT = 255;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_has = 0; m_known = 0; m_dir = 1; m_sticky = 0; m_err = 0;
        m_prev = 0; m_bounce = 0; m_flip = 0;
    endtask

    task automatic model_step(input int s, input bit iv, input bit c);
        bit rv, inr, ok;
        int d, hi, lo;
        m_err = 0;
        hi = int'(max);
        lo = int'(min);
        if (iv) begin
            rv  = hi > lo;
            inr = (s >= lo) && (s <= hi);
            if (!m_has) begin
                if (!rv || inr) begin m_has = 1; m_known = 0; end
                else m_err = 1;
            end else begin
                d  = s - m_prev;
                ok = rv ? (inr && d >= -1 && d <= 1) : (d == 0);
                if (!ok) begin
                    m_err = 1; m_has = inr; m_known = 0;
                end else if (d != 0) begin
                    if (!m_known) begin
                        m_known = 1; m_dir = (d > 0);
                    end else if ((d > 0) != m_dir) begin
                        if (m_prev == (m_dir ? hi : lo)) m_bounce = (m_bounce < SAT) ? m_bounce + 1 : SAT;
                        else                             m_flip   = (m_flip   < SAT) ? m_flip   + 1 : SAT;
                        m_dir = !m_dir;
                    end
                end
            end
            m_prev = s;
        end
        if (m_err) m_sticky = 1;
        if (c) begin m_bounce = 0; m_flip = 0; m_sticky = 0; end
    endtask

    task automatic cycle(input bit r, input bit iv, input int s, input bit c);
        rst_n = r; in_valid = iv; sample = s[3:0]; clr = c;
        @(posedge clk);
        if (!r) model_reset();
        else    model_step(s, iv, c);
        #1;
        check("dir",        dir,        m_dir);
        check("dir_valid",  dir_valid,  m_has && m_known);
        check("bounce_cnt", bounce_cnt, m_bounce);
        check("flip_cnt",   flip_cnt,   m_flip);
        check("step_err",   step_err,   m_err);
        check("err_sticky", err_sticky, m_sticky);
    endtask

    task automatic feed(input int s);
        cycle(1, 1, s, 0);
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0);
    endtask

    int gc, r;
    bit gdir;
    int s1[8] = '{2, 3, 4, 5, 4, 3, 2, 3};
    int d1[8] = '{1, 1, 1, 1, 0, 0, 0, 1};

    initial begin
        rst_n = 0; in_valid = 0; clr = 0; sample = 0; max = 0; min = 0;
        model_reset();

        // Reset state
        do_reset();
        check("rst_dir", dir, 1);
        check("rst_dir_valid", dir_valid, 0);

        // Bounces at both bounds
        min = 2; max = 5;
        for (int i = 0; i < 8; i++) begin
            feed(s1[i]);
            if (i >= 1) begin
                check("t1_dv", dir_valid, 1);
                check("t1_dir", dir, d1[i]);
            end
        end
        check("t1_bounce", bounce_cnt, 2);
        check("t1_flip", flip_cnt, 0);
        check("t1_sticky", err_sticky, 0);

        // Mid-range flips
        do_reset(); min = 0; max = 9;
        feed(3); feed(4); feed(5); feed(4); feed(5);
        check("t2_flip", flip_cnt, 2);
        check("t2_bounce", bounce_cnt, 0);
        check("t2_dir", dir, 1);

        // Holds keep FIRST
        do_reset();
        feed(3); feed(3); feed(3);
        check("t3_dv_hold", dir_valid, 0);
        feed(4);
        check("t3_dv", dir_valid, 1);
        check("t3_dir", dir, 1);

        // Jump of 2, resync, sticky until clr
        do_reset(); min = 2; max = 5;
        feed(2); feed(3); feed(5);
        check("t4_err", step_err, 1);
        check("t4_sticky", err_sticky, 1);
        check("t4_dv", dir_valid, 0);
        cycle(1, 0, 0, 0);
        check("t4_err_pulse", step_err, 0);
        feed(4);
        check("t4_dir", dir, 0);
        check("t4_dv2", dir_valid, 1);
        check("t4_sticky2", err_sticky, 1);
        cycle(1, 0, 0, 1);
        check("t4_clr", err_sticky, 0);

        // Wide step, out-of-range first sample, collapsed range
        do_reset(); min = 0; max = 15;
        feed(15); feed(0);
        check("t5_wrap_err", step_err, 1);
        do_reset(); max = 6;
        feed(7);
        check("t5_oor_err", step_err, 1);
        feed(3);
        check("t5_empty_first", dir_valid, 0);
        check("t5_no_err", step_err, 0);
        feed(4);
        check("t5_track", dir_valid, 1);
        do_reset(); min = 4; max = 4;
        feed(4);
        check("t5_eq_first", step_err, 0);
        feed(5);
        check("t5_eq_err", step_err, 1);

        // Saturation, clr with a bounce, mid-stream reset
        do_reset(); min = 0; max = 1;
        feed(0); feed(1);
        for (int i = 0; i < 300; i++) feed(i % 2);
        check("t6_sat", bounce_cnt, 255);
        cycle(1, 1, 0, 1);
        check("t6_clr_bounce", bounce_cnt, 0);
        check("t6_clr_dir", dir, 0);
        feed(1); feed(0);
        cycle(0, 1, 1, 1);
        check("t6_rst_dir", dir, 1);
        check("t6_rst_dv", dir_valid, 0);
        check("t6_rst_bounce", bounce_cnt, 0);
        check("t6_rst_err", step_err, 0);

        // Randomized counter-like traffic with glitches, bound changes, clr and resets
        min = 1; max = 12; gc = 1; gdir = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                min = 4'($urandom_range(0, 7));
                max = 4'($urandom_range(0, 15));
            end
            if (gc > int'(max)) gc = int'(max);
            if (gc < int'(min)) gc = int'(min);
            r = $urandom_range(0, 7);
            if (max <= min) r = 0;
            if (r == 1) gdir = !gdir;
            if (r != 0) begin
                if (gdir && gc >= int'(max))      gdir = 0;
                else if (!gdir && gc <= int'(min)) gdir = 1;
                gc = gdir ? gc + 1 : gc - 1;
            end
            cycle(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 15)) : gc,
                  ($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
